// File: rtl/mem_arbiter_if.sv
// Requester-port and shared-memory signal bundle for mem_arbiter.
interface mem_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ADDR  = 8
) ();
   logic             a_valid, b_valid;
   logic             a_wrbar, b_wrbar;
   logic [ADDR-1:0]  a_addr, b_addr;
   logic [WIDTH-1:0] a_wdata, b_wdata;
   logic             a_ready, b_ready;
   logic [WIDTH-1:0] a_rdata, b_rdata;
   logic             a_err, b_err;
   logic             mem_valid, mem_wrbar;
   logic [ADDR-1:0]  mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ready;

   // Arbiter view.
   modport slave (
      input  a_valid, b_valid, a_wrbar, b_wrbar, a_addr, b_addr, a_wdata, b_wdata,
      input  mem_rdata, mem_ready,
      output a_ready, b_ready, a_rdata, b_rdata, a_err, b_err,
      output mem_valid, mem_wrbar, mem_addr, mem_wdata
   );

   // Requesters plus memory, i.e. everything around the arbiter.
   modport master (
      output a_valid, b_valid, a_wrbar, b_wrbar, a_addr, b_addr, a_wdata, b_wdata,
      output mem_rdata, mem_ready,
      input  a_ready, b_ready, a_rdata, b_rdata, a_err, b_err,
      input  mem_valid, mem_wrbar, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single shared memory with response timeout.
// One transaction outstanding at a time: IDLE -> ISSUE -> RESP -> IDLE.
module mem_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ADDR  = 8,
   parameter int unsigned TMO   = 16
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   localparam logic [7:0] CntLast = 8'(TMO - 1);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;   // 0 = A, 1 = B
   logic             last_q, last_d;     // last granted port, 1 = B
   logic [7:0]       cnt_q, cnt_d;
   logic             wrbar_q, wrbar_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic [WIDTH-1:0] b_rdata_q, b_rdata_d;
   logic             err_q, err_d;
   logic             grant_b;

   // Round-robin pick: a lone requester wins; on a tie the port not granted last wins.
   always_comb begin
      if (bus.a_valid && bus.b_valid) begin
         grant_b = ~last_q;
      end else begin
         grant_b = bus.b_valid;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      wrbar_d   = wrbar_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.a_valid || bus.b_valid) begin
               owner_d = grant_b;
               wrbar_d = grant_b ? bus.b_wrbar : bus.a_wrbar;
               addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
               wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (bus.mem_ready) begin
               if (!wrbar_q) begin
                  if (owner_q) begin
                     b_rdata_d = bus.mem_rdata;
                  end else begin
                     a_rdata_d = bus.mem_rdata;
                  end
               end
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
               // Timed out: complete with error, rdata left untouched.
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            last_d  = owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset leaves B as last grant so A is favoured first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         wrbar_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         wrbar_q   <= wrbar_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.mem_valid = (state_q == StIssue);
   assign bus.mem_wrbar = wrbar_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.a_ready   = (state_q == StResp) && !owner_q;
   assign bus.b_ready   = (state_q == StResp) && owner_q;
   assign bus.a_err     = bus.a_ready && err_q;
   assign bus.b_err     = bus.b_ready && err_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data width.
REQ-002 Parameter: ADDR, 8, address width.
REQ-003 Parameter: TMO, 16, maximum cycles to wait for mem_ready before abort (range 2..255).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports exactly as listed below.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 a_valid, b_valid  in  1  request from port A/B; held until that port's ready.
REQ-008 a_wrbar, b_wrbar  in  1  1 = write, 0 = read.
REQ-009 a_addr, b_addr  in  ADDR  request address.
REQ-010 a_wdata, b_wdata  in  WIDTH  write data.
REQ-011 a_ready, b_ready  out  1  one-cycle completion pulse to A/B.
REQ-012 a_rdata, b_rdata  out  WIDTH  read data, registered, held until that port's next completion.
REQ-013 a_err, b_err  out  1  valid with ready; 1 = transaction timed out.
REQ-014 mem_valid, mem_wrbar  out  1  request to shared memory.
REQ-015 mem_addr  out  ADDR; mem_wdata  out  WIDTH  latched request fields.
REQ-016 mem_rdata  in  WIDTH; mem_ready  in  1  memory response.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP; exactly one memory transaction is outstanding at a time.
REQ-018 IDLE: at a rising edge with any valid high, the winner's wrbar/addr/wdata SHALL be latched, the owner recorded, and the FSM SHALL go to ISSUE.
REQ-019 Arbitration SHALL be round-robin: if only one port is valid it wins; if both are valid, the port not granted last wins; after reset A has priority.
REQ-020 ISSUE: mem_valid SHALL be 1 with the latched fields stable; a cycle counter SHALL start at 0 and increment each cycle.
REQ-021 ISSUE, mem_ready=1 sampled: for a read, mem_rdata SHALL be captured into the owner's rdata; the err flag SHALL be set to 0; the FSM SHALL go to RESP.
REQ-022 ISSUE, counter reaches TMO-1 with mem_ready=0: the FSM SHALL go to RESP with err=1, and rdata SHALL remain unchanged.
REQ-023 RESP: mem_valid SHALL be 0; the owner's ready SHALL be 1 for exactly this cycle; the other port's ready SHALL be 0; the last-grant pointer SHALL update to the owner; the next state SHALL be IDLE unconditionally.
REQ-024 Valid inputs SHALL be ignored in ISSUE and RESP; a requester SHALL change or drop its request in the cycle after its ready pulse.
REQ-025 Minimum latency SHALL be: valid sampled at edge k -> mem_valid in cycle k+1 -> mem_ready sampled at edge k+1 -> ready in cycle k+2; back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-026 In IDLE, mem_ready SHALL be ignored, and a request SHALL never be lost or duplicated.
REQ-027 mem_wdata SHALL be driven for reads as latched, and is don't-care to memory.

Reset
REQ-028 Asserting rst_n low at any time, including mid-ISSUE, SHALL immediately force: FSM=IDLE; mem_valid, a/b_ready, a/b_err = 0; mem_wrbar, mem_addr, mem_wdata, a/b_rdata = 0; pointer = B (A favoured); counter = 0.
REQ-029 An aborted transaction SHALL NOT be retried after reset, and no ready SHALL be issued for it.

Verification
REQ-030 Single A write addr 0x05 data 0xDEADBEEF, mem_ready tied high -> mem_valid for one cycle with those fields; a_ready pulses 2 cycles after valid is sampled; a_err=0.
REQ-031 A and B both read continuously (A addr 0x10, B addr 0x20), memory returns addr+0x100 -> grants alternate A,B,A,B; a_rdata=0x110 and b_rdata=0x120; no port is served twice in a row.
REQ-032 B alone, then A and B together -> B served, then A wins the tie.
REQ-033 mem_ready held 0, TMO=16 -> mem_valid high for 16 cycles, then owner ready=1 with err=1, rdata unchanged; the next request proceeds normally.
REQ-034 rst_n asserted during ISSUE -> all outputs are 0 asynchronously; no ready pulse follows release; the next A request is granted first.
REQ-035 Full sweep: A writes addresses 0..255 while B reads 0..255 interleaved -> every read returns the last data written to that address per memory model; 512 ready pulses in total.
